// File: rtl/ibex_pkg.sv
// Shared Ibex types: interrupt source vector, exception cause encoding and
// the cause constants used by the interrupt arbiter.
package ibex_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef struct packed {
        logic       irq_ext;
        logic       irq_int;
        logic [4:0] lower_cause;
    } exc_cause_t;

    localparam int unsigned NumIrqs        = 18;
    localparam int unsigned IrqIdxSoftware = 17;
    localparam int unsigned IrqIdxTimer    = 16;
    localparam int unsigned IrqIdxExternal = 15;

    localparam exc_cause_t ExcCauseIrqSoftwareM = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd3};
    localparam exc_cause_t ExcCauseIrqTimerM    = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd7};
    localparam exc_cause_t ExcCauseIrqExternalM = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd11};
    localparam exc_cause_t ExcCauseIrqFastBase  = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd16};
    localparam exc_cause_t ExcCauseIrqNm        = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd31};

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbReq  = 1'b1
    } irq_arb_state_e;

    function automatic exc_cause_t irq_fast_cause(input logic [3:0] idx);
        exc_cause_t c;
        c             = ExcCauseIrqFastBase;
        c.lower_cause = ExcCauseIrqFastBase.lower_cause + {1'b0, idx};
        return c;
    endfunction

endpackage

// File: rtl/ibex_irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines, cleared by the
// arbiter's asynchronous reset.
module ibex_irq_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_q, stage1_d;
    logic [Width-1:0] stage2_q, stage2_d;

    assign stage1_d = d_i;
    assign stage2_d = stage1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Fixed-priority interrupt arbiter with NMI latch, NMI mode and cause upgrade.
// Define IBEX_IRQ_ARBITER_SYNC_EN to insert a 2-flop input synchroniser.
module ibex_irq_arbiter
    import ibex_pkg::*;
#(
    parameter bit NmiEdge = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  irqs_t      irqs_i,
    input  logic       irq_nm_i,
    input  irqs_t      mie_i,
    input  logic       mstatus_mie_i,
    input  logic       irq_ack_i,
    input  logic       nmi_clear_i,
    output logic       irq_req_o,
    output exc_cause_t irq_cause_o,
    output irqs_t      irq_pending_o,
    output logic       nmi_mode_o
);

    irqs_t irqs_s;
    logic  irq_nm_s;

`ifdef IBEX_IRQ_ARBITER_SYNC_EN
    logic [NumIrqs:0] sync_out;

    ibex_irq_sync #(
        .Width(NumIrqs + 1)
    ) u_irq_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   ({irq_nm_i, irqs_i}),
        .q_o   (sync_out)
    );

    assign irqs_s   = irqs_t'(sync_out[NumIrqs-1:0]);
    assign irq_nm_s = sync_out[NumIrqs];
`else
    assign irqs_s   = irqs_i;
    assign irq_nm_s = irq_nm_i;
`endif

    irqs_t          pending_q, pending_d;
    logic           nmi_prev_q, nmi_prev_d;
    logic           nmi_latch_q, nmi_latch_d;
    logic           nmi_mode_q, nmi_mode_d;
    irq_arb_state_e state_q, state_d;
    exc_cause_t     cause_q, cause_d;
    logic [4:0]     src_idx_q, src_idx_d;

    logic [NumIrqs-1:0] mask_qual;
    logic               nmi_qual;
    logic               nmi_set;
    logic               nmi_ack;
    logic               cause_is_nmi;
    logic               win_valid;
    logic [4:0]         win_idx;
    exc_cause_t         win_cause;

    assign pending_d  = irqs_s;
    assign nmi_prev_d = irq_nm_s;

    assign mask_qual    = pending_q & mie_i & {NumIrqs{mstatus_mie_i & ~nmi_mode_q}};
    assign nmi_qual     = nmi_latch_q & ~nmi_mode_q;
    assign nmi_set      = NmiEdge ? (irq_nm_s & ~nmi_prev_q) : irq_nm_s;
    assign cause_is_nmi = (cause_q == ExcCauseIrqNm);

    // Lowest priority first so later, higher-priority hits override.
    always_comb begin
        win_valid = |mask_qual;
        win_idx   = 5'(IrqIdxTimer);
        win_cause = ExcCauseIrqTimerM;
        if (mask_qual[IrqIdxSoftware]) begin
            win_idx   = 5'(IrqIdxSoftware);
            win_cause = ExcCauseIrqSoftwareM;
        end
        if (mask_qual[IrqIdxExternal]) begin
            win_idx   = 5'(IrqIdxExternal);
            win_cause = ExcCauseIrqExternalM;
        end
        for (int i = 0; i < 15; i++) begin
            if (mask_qual[i]) begin
                win_idx   = 5'(i);
                win_cause = irq_fast_cause(4'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        src_idx_d = src_idx_q;
        nmi_ack   = 1'b0;
        case (state_q)
            ArbIdle: begin
                if (nmi_qual) begin
                    cause_d = ExcCauseIrqNm;
                    state_d = ArbReq;
                end else if (win_valid) begin
                    cause_d   = win_cause;
                    src_idx_d = win_idx;
                    state_d   = ArbReq;
                end
            end
            ArbReq: begin
                // An ack takes precedence over a coincident NMI upgrade.
                if (irq_ack_i) begin
                    state_d = ArbIdle;
                    nmi_ack = cause_is_nmi;
                end else if (!cause_is_nmi) begin
                    if (nmi_qual) begin
                        cause_d = ExcCauseIrqNm;
                    end else if (!mask_qual[src_idx_q]) begin
                        state_d = ArbIdle;
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    assign nmi_latch_d = nmi_set | (nmi_latch_q & ~nmi_ack);
    assign nmi_mode_d  = nmi_ack | (nmi_mode_q & ~nmi_clear_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            nmi_prev_q  <= 1'b0;
            nmi_latch_q <= 1'b0;
            nmi_mode_q  <= 1'b0;
            state_q     <= ArbIdle;
            cause_q     <= '0;
            src_idx_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            nmi_prev_q  <= nmi_prev_d;
            nmi_latch_q <= nmi_latch_d;
            nmi_mode_q  <= nmi_mode_d;
            state_q     <= state_d;
            cause_q     <= cause_d;
            src_idx_q   <= src_idx_d;
        end
    end

    assign irq_req_o     = (state_q == ArbReq);
    assign irq_cause_o   = cause_q;
    assign irq_pending_o = pending_q;
    assign nmi_mode_o    = nmi_mode_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Directed cycle-by-cycle vector bench for ibex_irq_arbiter (default build,
// no input synchroniser), plus a hand-written asynchronous reset sequence.
module tb_ibex_irq_arbiter;

    localparam logic [17:0] T     = 18'h10000;
    localparam logic [17:0] S     = 18'h20000;
    localparam logic [17:0] E     = 18'h08000;
    localparam logic [17:0] F3    = 18'h00008;
    localparam logic [17:0] F14   = 18'h04000;
    localparam logic [17:0] F0    = 18'h00001;
    localparam logic [17:0] ALL   = 18'h3FFFF;
    localparam logic [17:0] NOT_T = 18'h2FFFF;

    localparam logic [6:0] C_T   = 7'h47;
    localparam logic [6:0] C_S   = 7'h43;
    localparam logic [6:0] C_E   = 7'h4B;
    localparam logic [6:0] C_F3  = 7'h53;
    localparam logic [6:0] C_F14 = 7'h5E;
    localparam logic [6:0] C_NM  = 7'h5F;

    logic        clk;
    logic        rst_n;
    logic [17:0] irqs;
    logic        irq_nm;
    logic [17:0] mie;
    logic        mstatus_mie;
    logic        irq_ack;
    logic        nmi_clear;
    logic        irq_req;
    logic [6:0]  irq_cause;
    logic [17:0] irq_pending;
    logic        nmi_mode;

    int errors = 0;
    int checks = 0;

    ibex_irq_arbiter #(.NmiEdge(1'b1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irqs_i       (irqs),
        .irq_nm_i     (irq_nm),
        .mie_i        (mie),
        .mstatus_mie_i(mstatus_mie),
        .irq_ack_i    (irq_ack),
        .nmi_clear_i  (nmi_clear),
        .irq_req_o    (irq_req),
        .irq_cause_o  (irq_cause),
        .irq_pending_o(irq_pending),
        .nmi_mode_o   (nmi_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] irqs;
        logic        nm;
        logic [17:0] mie;
        logic        mst;
        logic        ack;
        logic        clr;
        logic        exp_req;
        logic [6:0]  exp_cause;
        logic        exp_nmode;
        logic [17:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [17:0] i_irqs, input logic i_nm, input logic [17:0] i_mie,
                       input logic i_mst, input logic i_ack, input logic i_clr,
                       input logic e_req, input logic [6:0] e_cause, input logic e_nmode,
                       input logic [17:0] e_pend);
        vec_t v;
        v.irqs = i_irqs; v.nm = i_nm; v.mie = i_mie; v.mst = i_mst;
        v.ack = i_ack; v.clr = i_clr; v.exp_req = e_req; v.exp_cause = e_cause;
        v.exp_nmode = e_nmode; v.exp_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; irqs = '0; irq_nm = 1'b0; mie = ALL; mstatus_mie = 1'b1;
        irq_ack = 1'b0; nmi_clear = 1'b0;

        // Timer only
        add(T, 0, ALL, 1, 0, 0, 0, 0, 0, T);
        add(T, 0, ALL, 1, 0, 0, 1, C_T, 0, T);
        add(0, 0, ALL, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        // fast[3] + external + software, then external after ack
        add(F3|E|S, 0, ALL, 1, 0, 0, 0, 0, 0, F3|E|S);
        add(F3|E|S, 0, ALL, 1, 0, 0, 1, C_F3, 0, F3|E|S);
        add(E|S, 0, ALL, 1, 1, 0, 0, 0, 0, E|S);
        add(E|S, 0, ALL, 1, 0, 0, 1, C_E, 0, E|S);
        add(S, 0, ALL, 1, 1, 0, 0, 0, 0, S);
        // Software in REQ upgraded by NMI, then NMI mode and second NMI
        add(S, 0, ALL, 1, 0, 0, 1, C_S, 0, S);
        add(S, 1, ALL, 1, 0, 0, 1, C_S, 0, S);
        add(S, 1, ALL, 1, 0, 0, 1, C_NM, 0, S);
        add(S, 0, ALL, 1, 1, 0, 0, 0, 1, S);
        add(T|S, 0, ALL, 1, 0, 0, 0, 0, 1, T|S);
        add(T, 1, ALL, 1, 0, 0, 0, 0, 1, T);
        add(T, 0, ALL, 1, 0, 0, 0, 0, 1, T);
        add(T, 0, ALL, 1, 0, 1, 0, 0, 0, T);
        add(T, 0, ALL, 1, 0, 0, 1, C_NM, 0, T);
        add(T, 0, ALL, 1, 1, 0, 0, 0, 1, T);
        add(0, 0, ALL, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        // External in REQ, global MIE cleared
        add(E, 0, ALL, 1, 0, 0, 0, 0, 0, E);
        add(E, 0, ALL, 1, 0, 0, 1, C_E, 0, E);
        add(E, 0, ALL, 0, 0, 0, 0, 0, 0, E);
        add(0, 0, ALL, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        // Timer masked by mie
        add(T, 0, NOT_T, 1, 0, 0, 0, 0, 0, T);
        add(T, 0, NOT_T, 1, 0, 0, 0, 0, 0, T);
        add(0, 0, NOT_T, 1, 0, 0, 0, 0, 0, 0);
        // Source deasserted in REQ without ack
        add(S, 0, ALL, 1, 0, 0, 0, 0, 0, S);
        add(S, 0, ALL, 1, 0, 0, 1, C_S, 0, S);
        add(0, 0, ALL, 1, 0, 0, 1, C_S, 0, 0);
        add(0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        // Ack coincides with NMI upgrade: ack wins, NMI after one IDLE cycle
        add(T, 0, ALL, 1, 0, 0, 0, 0, 0, T);
        add(T, 0, ALL, 1, 0, 0, 1, C_T, 0, T);
        add(T, 1, ALL, 1, 0, 0, 1, C_T, 0, T);
        add(0, 1, ALL, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, ALL, 1, 0, 0, 1, C_NM, 0, 0);
        add(0, 0, ALL, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, ALL, 1, 0, 1, 0, 0, 0, 0);
        // fast[14] beats fast[0]; ack in IDLE ignored
        add(F14|F0, 0, ALL, 1, 0, 0, 0, 0, 0, F14|F0);
        add(F14|F0, 0, ALL, 1, 0, 0, 1, C_F14, 0, F14|F0);
        add(0, 0, ALL, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, ALL, 1, 1, 0, 0, 0, 0, 0);

        #1;
        chk("rst_req", -1, 32'(irq_req), 32'd0);
        chk("rst_cause", -1, 32'(irq_cause), 32'd0);
        chk("rst_pend", -1, 32'(irq_pending), 32'd0);
        chk("rst_nmode", -1, 32'(nmi_mode), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            irqs = vecs[i].irqs; irq_nm = vecs[i].nm; mie = vecs[i].mie;
            mstatus_mie = vecs[i].mst; irq_ack = vecs[i].ack; nmi_clear = vecs[i].clr;
            @(posedge clk);
            #1;
            chk("req", i, 32'(irq_req), 32'(vecs[i].exp_req));
            chk("nmi_mode", i, 32'(nmi_mode), 32'(vecs[i].exp_nmode));
            chk("pending", i, 32'(irq_pending), 32'(vecs[i].exp_pend));
            if (vecs[i].exp_req) chk("cause", i, 32'(irq_cause), 32'(vecs[i].exp_cause));
            $display("step %0d irqs=%05h nm=%0b ack=%0b clr=%0b -> req=%0b cause=%02h nmode=%0b pend=%05h",
                     i, vecs[i].irqs, vecs[i].nm, vecs[i].ack, vecs[i].clr,
                     irq_req, irq_cause, nmi_mode, irq_pending);
        end

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        irqs = T; irq_nm = 1'b0; mie = ALL; mstatus_mie = 1'b1; irq_ack = 1'b0; nmi_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_req", 100, 32'(irq_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 101, 32'(irq_req), 32'd0);
        chk("async_rst_cause", 101, 32'(irq_cause), 32'd0);
        chk("async_rst_pend", 101, 32'(irq_pending), 32'd0);
        chk("async_rst_nmode", 101, 32'(nmi_mode), 32'd0);
        $display("async reset mid-REQ -> req=%0b cause=%02h pend=%05h", irq_req, irq_cause, irq_pending);
        @(negedge clk);
        irqs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_req", 102 + k, 32'(irq_req), 32'd0);
            chk("post_rst_pend", 102 + k, 32'(irq_pending), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
IBEX_IRQ_ARBITER -- requirements
Module: ibex_irq_arbiter

Interface
REQ-001 SHALL have parameter NmiEdge, default 1: 1 = irq_nm_i is rising-edge latched; 0 = irq_nm_i is level-sensitive.
REQ-002 SHALL have ports:
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- irqs_i  input  18  irqs_t, raw level interrupt sources {software, timer, external, fast[14:0]}.
- irq_nm_i  input  1  non-maskable interrupt source.
- mie_i  input  18  irqs_t, per-source enables.
- mstatus_mie_i  input  1  global machine interrupt enable.
- irq_ack_i  input  1  core accepts the current request.
- nmi_clear_i  input  1  one-cycle pulse on return from the NMI handler.
- irq_req_o  output  1  interrupt request to the controller.
- irq_cause_o  output  7  exc_cause_t of the request.
- irq_pending_o  output  18  irqs_t, registered pending view (mip).
- nmi_mode_o  output  1  NMI handler active.

Function
REQ-003 SHALL register irqs_i into irq_pending_o each cycle; pending is level-following, with no sticky bits.
REQ-004 SHALL set the NMI latch on a rising edge of irq_nm_i (NmiEdge=1) or while irq_nm_i=1 (NmiEdge=0), and clear it on irq_ack_i accepting an NMI cause.
REQ-005 SHALL qualify maskable sources as pending & mie_i & mstatus_mie_i & ~nmi_mode_o; the NMI latch SHALL qualify only when ~nmi_mode_o.
REQ-006 SHALL use fixed priority: NMI > fast[14] > ... > fast[0] > external > software > timer.
REQ-007 SHALL encode causes as: NMI={1,0,31}; fast i={1,0,16+i}; external={1,0,11}; software={1,0,3}; timer={1,0,7}.
REQ-008 SHALL implement an FSM with states IDLE and REQ:
- IDLE: if any source qualifies, latch the winner's cause and enter REQ; irq_req_o=1 from the next cycle.
- REQ: irq_req_o=1 and irq_cause_o is held stable.
- REQ, irq_ack_i=1: return to IDLE. The request drops the following cycle, with at least one IDLE cycle before the next request.
REQ-009 If the latched maskable source stops qualifying in REQ without an ack (deasserted, masked, or MIE cleared), SHALL return to IDLE and drop irq_req_o the next cycle.
REQ-010 In REQ with a maskable cause, a newly qualifying NMI SHALL replace irq_cause_o with the NMI cause the next cycle without dropping irq_req_o. No other cause change is permitted while in REQ.
REQ-011 When irq_ack_i and an NMI upgrade coincide, the ack SHALL win: the original cause is consumed, and the NMI is requested after the mandatory IDLE cycle.
REQ-012 nmi_mode_o SHALL set the cycle after an NMI ack and clear the cycle after nmi_clear_i. Simultaneous set and clear SHALL leave it set.
REQ-013 irq_ack_i in IDLE SHALL be ignored.
REQ-014 Latency, synchronizer absent: a source high before edge 0 SHALL make irq_req_o=1 after edge 1.

Reset
REQ-015 Asserting rst_ni=0 SHALL immediately force: irq_req_o=0, irq_cause_o=0, irq_pending_o=0, nmi_mode_o=0, NMI latch=0, FSM=IDLE, NMI edge-detect history=0.
REQ-016 Reset mid-REQ SHALL discard the request with no residual pending state; deassertion SHALL be synchronous to clk_i through the existing reset synchronizer.

Configuration
REQ-017 Macro IBEX_IRQ_ARBITER_SYNC_EN defined: irqs_i and irq_nm_i SHALL pass through a 2-flop synchronizer, adding 2 cycles to REQ-014 latency (request after edge 3).
REQ-018 Macro absent: inputs SHALL be sampled directly with no synchronizer flops.

Structure
REQ-019 irqs_t, exc_cause_t and ExcCause* constants SHALL come from ibex_pkg; ExcCauseIrqFastBase (lower_cause 16) SHALL be added to ibex_pkg.
REQ-020 The synchronizer SHALL be a sub-module ibex_irq_sync (parameterised width, 2 flops, same clock and reset), instantiated only under IBEX_IRQ_ARBITER_SYNC_EN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Timer only, mie_i=all-ones, mstatus_mie_i=1 -> irq_req_o=1 with cause {1,0,7} after edge 1; ack -> req=0 next cycle.
- fast[3], external and software simultaneously -> cause {1,0,19}; after ack with fast[3] dropped -> external {1,0,11} after one IDLE cycle.
- Software request pending in REQ, irq_nm_i rises -> cause becomes {1,0,31} next cycle with req held high.
- External in REQ, mstatus_mie_i cleared before ack -> req=0 next cycle, FSM IDLE.
- NMI acked -> nmi_mode_o=1 and timer masked; second NMI edge stays latched; nmi_clear_i -> second NMI requested.
- rst_ni low mid-REQ -> all outputs 0 immediately; after release with sources low, no request.
